// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared types for the dual-issue instruction-fetch stage:
//   - if_id_port_t   : bundle presented to the IF/ID pipeline register
//   - fetch_entry_t  : one fetch-queue entry (an instruction pair)
//   - fetch_state_e  : fetch-unit FSM states
//   - RESET_PC_DEFAULT : MIPS boot vector
// Optional macro IF_PREDECODE_EN adds isbr0/isbr1 branch hints to the port
// bundle together with the is_branch() predecode helper.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic        valid0;
        logic        valid1;
`ifdef IF_PREDECODE_EN
        logic        isbr0;
        logic        isbr1;
`endif
    } if_id_port_t;

    // A queue entry carries exactly what is later presented downstream.
    typedef if_id_port_t fetch_entry_t;

`ifdef IF_PREDECODE_EN
    // Control-transfer detection: REGIMM, J, JAL, BEQ..BGTZ, and JR/JALR.
    function automatic logic is_branch(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] funct;
        op    = inst[31:26];
        funct = inst[5:0];
        return ((op >= 6'h01) && (op <= 6'h07)) ||
               ((op == 6'h00) && ((funct == 6'h08) || (funct == 6'h09)));
    endfunction
`endif

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response bundle.
//   req_valid / req_ready / req_addr : 8-byte aligned pair request
//   rsp_valid / rsp_data             : in-order, non-back-pressurable reply,
//                                      [31:0] word at addr, [63:32] at addr+4
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Synchronous FIFO of fetch_entry_t with a combinational head.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : flush all entries (wins over push and pop)
//   push, push_data : write one entry
//   pop             : retire the head (ignored while empty)
//   head            : current head entry, all-zero when empty
//   count, empty    : occupancy
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           pop_eff;

    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign pop_eff = pop && !empty;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop_eff);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage of the dual-issue MIPS pipeline. Generates the
// fetch PC, issues aligned 64-bit requests, queues returned pairs and
// presents the queue head to the IF/ID register. Redirects flush the queue
// and discard responses still in flight.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   stall        : downstream stall (head is held)
//   redir_valid  : redirect request (highest priority)
//   redir_pc     : redirect target, word aligned
//   imem         : instruction-memory bundle (master side)
//   out          : IF/ID port bundle driven from the queue head
// Optional macro IF_PREDECODE_EN adds isbr0/isbr1 branch hints on push.
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH  = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redir_valid,
    input  logic [31:0]          redir_pc,
    if_fetch_unit_if.master      imem,
    output if_id_port_t          out
);
    localparam int OCW = $clog2(MAX_OUTST + 1);
    localparam int TW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    fetch_state_e          state_reg;
    logic [31:0]           pc_reg;
    logic [OCW-1:0]        outst_reg;
    logic [OCW-1:0]        drop_reg;
    logic [OCW-1:0]        outst_next;
    logic [31:0]           tag_pc_reg [MAX_OUTST];
    logic [TW-1:0]         tag_wr_reg;
    logic [TW-1:0]         tag_rd_reg;

    logic [$clog2(FQ_DEPTH):0] q_count;
    logic                  q_empty;
    logic                  req_valid;
    logic                  hs;
    logic                  rsp;
    logic                  push;
    logic                  pop;
    logic [31:0]           rsp_pc;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        if (32'(p) == 32'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + TW'(1);
    endfunction

    // Credit rule: queued plus in-flight pairs never exceed the queue, so a
    // response always finds a free slot.
    assign req_valid = (state_reg != S_BOOT) &&
                       (32'(outst_reg) < 32'(MAX_OUTST)) &&
                       ((32'(q_count) + 32'(outst_reg)) < 32'(FQ_DEPTH));

    assign imem.req_valid = req_valid;
    assign imem.req_addr  = {pc_reg[31:3], 3'b000};

    assign hs         = req_valid && imem.req_ready;
    assign rsp        = imem.rsp_valid;
    assign outst_next = outst_reg + OCW'(hs) - OCW'(rsp);

    // Responses return in order, so the oldest tag belongs to this response.
    assign rsp_pc = tag_pc_reg[tag_rd_reg];
    assign push   = rsp && !redir_valid && (drop_reg == '0);
    assign pop    = !q_empty && !stall && !redir_valid;

`ifdef IF_PREDECODE_EN
    logic [31:0] slot_inst [2];
    logic [1:0]  slot_valid;
    logic [1:0]  slot_isbr;

    assign slot_inst[0] = imem.rsp_data[31:0];
    assign slot_inst[1] = imem.rsp_data[63:32];
    assign slot_valid   = {1'b1, ~rsp_pc[2]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_predecode
            assign slot_isbr[gi] = slot_valid[gi] & is_branch(slot_inst[gi]);
        end
    endgenerate
`endif

    always_comb begin
        push_entry        = '0;
        push_entry.pc     = rsp_pc;
        push_entry.inst0  = imem.rsp_data[31:0];
        push_entry.inst1  = imem.rsp_data[63:32];
        // A request to an odd word has no useful instruction in slot 0.
        push_entry.valid0 = ~rsp_pc[2];
        push_entry.valid1 = 1'b1;
`ifdef IF_PREDECODE_EN
        push_entry.isbr0  = slot_isbr[0];
        push_entry.isbr1  = slot_isbr[1];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_BOOT;
            pc_reg     <= RESET_PC;
            outst_reg  <= '0;
            drop_reg   <= '0;
            tag_wr_reg <= '0;
            tag_rd_reg <= '0;
        end else begin
            outst_reg <= outst_next;
            // Tag pointers keep tracking stale requests across redirects so
            // they stay aligned with the in-order response stream.
            if (hs) begin
                tag_wr_reg <= tag_inc(tag_wr_reg);
            end
            if (rsp) begin
                tag_rd_reg <= tag_inc(tag_rd_reg);
            end

            if (redir_valid) begin
                // Everything still in flight after this cycle is stale,
                // including a request that handshakes right now; a response
                // arriving now is discarded without consuming drop credit.
                pc_reg    <= redir_pc;
                drop_reg  <= outst_next;
                state_reg <= (outst_next != '0) ? S_DRAIN : S_FETCH;
            end else begin
                if (hs) begin
                    pc_reg <= {pc_reg[31:3], 3'b000} + 32'd8;
                end
                if (rsp && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - OCW'(1);
                end
                unique case (state_reg)
                    S_BOOT: begin
                        state_reg <= S_FETCH;
                    end
                    S_DRAIN: begin
                        if ((drop_reg == '0) || (rsp && (drop_reg == OCW'(1)))) begin
                            state_reg <= S_FETCH;
                        end
                    end
                    default: begin
                        state_reg <= S_FETCH;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            tag_pc_reg[tag_wr_reg] <= pc_reg;
        end
    end

    if_fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (redir_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (q_count),
        .empty     (q_empty)
    );

    assign out = head;
endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed self-checking bench for if_fetch_unit with a fixed-latency
// instruction-memory model (latency 1..4, always ready).
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    if_id_port_t out;

    int lat = 1;
    int n_cmp = 0;
    int n_fail = 0;

    logic        pipe_v [4];
    logic [31:0] pipe_a [4];

    if_fetch_unit_if mif();

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC  (32'hBFC0_0000),
        .FQ_DEPTH  (4),
        .MAX_OUTST (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem        (mif),
        .out         (out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1022_0003; // BEQ
            32'h0000_0104: return 32'h0022_1821; // ADDU
            32'h0000_0208: return 32'h0800_0040; // J
            32'h0000_020C: return 32'h03E0_0008; // JR $ra
            default:       return a ^ 32'hFC00_0000;
        endcase
    endfunction

    // Expected pair for a request made at pc (branch hints default to 0).
    function automatic if_id_port_t exp_pair(input logic [31:0] pc);
        if_id_port_t e;
        logic [31:0] al;
        e        = '0;
        al       = {pc[31:3], 3'b000};
        e.pc     = pc;
        e.inst0  = mem_word(al);
        e.inst1  = mem_word(al + 32'd4);
        e.valid0 = ~pc[2];
        e.valid1 = 1'b1;
        return e;
    endfunction

    // Memory model: in-order fixed-latency pipe, cleared by the shared reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= mif.req_valid && mif.req_ready;
            pipe_a[0] <= mif.req_addr;
            for (int i = 1; i < 4; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign mif.rsp_valid = pipe_v[lat-1];
    assign mif.rsp_data  = {mem_word(pipe_a[lat-1] + 32'd4), mem_word(pipe_a[lat-1])};

    task automatic do_reset(input int l);
        @(negedge clk);
        rst         = 1'b1;
        stall       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        lat         = l;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1);
        n_cmp++;
        if (out !== '0) begin
            n_fail++; $display("FAIL reset_out: got %h want 0", out);
        end
        n_cmp++;
        if (mif.req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_boot_req: got %b want 0", mif.req_valid);
        end
        $display("reset: out=%h req_valid=%b", out, mif.req_valid);
        @(negedge clk);
        n_cmp++;
        if (mif.req_valid !== 1'b1 || mif.req_addr !== 32'hBFC0_0000) begin
            n_fail++; $display("FAIL first_req: got v=%b a=%h want v=1 a=bfc00000", mif.req_valid, mif.req_addr);
        end
        $display("first_req: v=%b addr=%h", mif.req_valid, mif.req_addr);
        @(negedge clk);
        n_cmp++;
        if (out.valid1 !== 1'b0) begin
            n_fail++; $display("FAIL early_out: got valid1=%b want 0", out.valid1);
        end
    endtask

    task automatic test_stream();
        if_id_port_t e;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = exp_pair(32'hBFC0_0000 + 32'(8 * k));
            n_cmp++;
            if (out !== e) begin
                n_fail++; $display("FAIL stream[%0d]: got %h want %h", k, out, e);
            end
            $display("stream[%0d]: pc=%h v0=%b v1=%b", k, out.pc, out.valid0, out.valid1);
        end
    endtask

    task automatic test_stall();
        logic [31:0] h;
        if_id_port_t e;
        @(negedge clk);
        h = 32'hBFC0_0030;
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = exp_pair(h);
            n_cmp++;
            if (out !== e) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, out, e);
            end
            if (i >= 2) begin
                n_cmp++;
                if (mif.req_valid !== 1'b0) begin
                    n_fail++; $display("FAIL stall_full[%0d]: req_valid got %b want 0", i, mif.req_valid);
                end
            end
            $display("stall[%0d]: pc=%h req_valid=%b", i, out.pc, mif.req_valid);
            @(negedge clk);
        end
        stall = 1'b0;
        for (int j = 0; j < 8; j++) begin
            e = exp_pair(h + 32'(8 * j));
            n_cmp++;
            if (out !== e) begin
                n_fail++; $display("FAIL stall_release[%0d]: got %h want %h", j, out, e);
            end
            $display("release[%0d]: pc=%h", j, out.pc);
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        if_id_port_t e;
        do_reset(3);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mif.req_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_outst_full: req_valid got %b want 0", mif.req_valid);
        end
        redir_valid = 1'b1;
        redir_pc    = 32'h8000_0014;
        @(negedge clk);
        redir_valid = 1'b0;
        n_cmp++;
        if (mif.req_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_no_req: req_valid got %b want 0", mif.req_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (mif.req_valid !== 1'b1 || mif.req_addr !== 32'h8000_0010) begin
            n_fail++; $display("FAIL redir_req: got v=%b a=%h want v=1 a=80000010", mif.req_valid, mif.req_addr);
        end
        $display("redir_req: v=%b addr=%h", mif.req_valid, mif.req_addr);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out !== '0) begin
                n_fail++; $display("FAIL redir_stale[%0d]: got %h want 0", i, out);
            end
            @(negedge clk);
        end
        e = exp_pair(32'h8000_0014);
        n_cmp++;
        if (out !== e) begin
            n_fail++; $display("FAIL redir_first: got %h want %h", out, e);
        end
        $display("redir_first: pc=%h v0=%b v1=%b inst1=%h", out.pc, out.valid0, out.valid1, out.inst1);
        @(negedge clk);
        e = exp_pair(32'h8000_0018);
        n_cmp++;
        if (out !== e) begin
            n_fail++; $display("FAIL redir_second: got %h want %h", out, e);
        end
    endtask

    task automatic test_redir_collide();
        if_id_port_t e;
        do_reset(3);
        repeat (5) @(negedge clk);
        e = exp_pair(32'hBFC0_0000);
        n_cmp++;
        if (out !== e || mif.req_valid !== 1'b1) begin
            n_fail++; $display("FAIL collide_pre: got %h v=%b want %h v=1", out, mif.req_valid, e);
        end
        redir_valid = 1'b1;
        redir_pc    = 32'h8000_0100;
        @(negedge clk);
        redir_valid = 1'b0;
        n_cmp++;
        if (mif.req_valid !== 1'b1 || mif.req_addr !== 32'h8000_0100) begin
            n_fail++; $display("FAIL collide_req: got v=%b a=%h want v=1 a=80000100", mif.req_valid, mif.req_addr);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out !== '0) begin
                n_fail++; $display("FAIL collide_stale[%0d]: got %h want 0", i, out);
            end
            @(negedge clk);
        end
        e = exp_pair(32'h8000_0100);
        n_cmp++;
        if (out !== e) begin
            n_fail++; $display("FAIL collide_first: got %h want %h", out, e);
        end
        $display("collide_first: pc=%h v0=%b v1=%b", out.pc, out.valid0, out.valid1);
    endtask

    task automatic test_wrap();
        if_id_port_t e;
        do_reset(1);
        repeat (6) @(negedge clk);
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        redir_valid = 1'b0;
        n_cmp++;
        if (mif.req_valid !== 1'b1 || mif.req_addr !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_req0: got v=%b a=%h want v=1 a=fffffff8", mif.req_valid, mif.req_addr);
        end
        n_cmp++;
        if (out !== '0) begin
            n_fail++; $display("FAIL wrap_flush: got %h want 0", out);
        end
        @(negedge clk);
        n_cmp++;
        if (mif.req_addr !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_req1: got a=%h want 00000000", mif.req_addr);
        end
        $display("wrap_req1: addr=%h", mif.req_addr);
        @(negedge clk);
        e = exp_pair(32'hFFFF_FFF8);
        n_cmp++;
        if (out !== e) begin
            n_fail++; $display("FAIL wrap_out0: got %h want %h", out, e);
        end
        @(negedge clk);
        e = exp_pair(32'h0000_0000);
        n_cmp++;
        if (out !== e) begin
            n_fail++; $display("FAIL wrap_out1: got %h want %h", out, e);
        end
    endtask

    task automatic test_midstream_reset();
        if_id_port_t e;
        do_reset(1);
        stall = 1'b1;
        repeat (8) @(negedge clk);
        e = exp_pair(32'hBFC0_0000);
        n_cmp++;
        if (mif.req_valid !== 1'b0 || out !== e) begin
            n_fail++; $display("FAIL mid_full: got v=%b out=%h want v=0 out=%h", mif.req_valid, out, e);
        end
        rst   = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out !== '0 || mif.req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got out=%h v=%b want 0/0", out, mif.req_valid);
        end
        $display("mid_reset: out=%h req_valid=%b", out, mif.req_valid);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mif.req_valid !== 1'b1 || mif.req_addr !== 32'hBFC0_0000) begin
            n_fail++; $display("FAIL mid_restart_req: got v=%b a=%h want v=1 a=bfc00000", mif.req_valid, mif.req_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out !== e) begin
            n_fail++; $display("FAIL mid_restart_out: got %h want %h", out, e);
        end
    endtask

`ifdef IF_PREDECODE_EN
    task automatic test_predecode();
        if_id_port_t e;
        logic        found;
        logic [31:0] tgt [2];
        tgt[0] = 32'h0000_0100;
        tgt[1] = 32'h0000_020C;
        do_reset(1);
        repeat (4) @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            redir_valid = 1'b1;
            redir_pc    = tgt[t];
            @(negedge clk);
            redir_valid = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                if (out.valid1 === 1'b1 && out.pc === tgt[t]) found = 1'b1;
                else @(negedge clk);
            end
            e = exp_pair(tgt[t]);
            e.isbr0 = (t == 0);
            e.isbr1 = (t == 1);
            n_cmp++;
            if (!found || out !== e) begin
                n_fail++; $display("FAIL predecode[%0d]: got %h want %h (seen=%b)", t, out, e, found);
            end
            $display("predecode[%0d]: pc=%h isbr0=%b isbr1=%b", t, out.pc, out.isbr0, out.isbr1);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        redir_valid   = 1'b0;
        redir_pc      = 32'h0;
        mif.req_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redir_collide();
        test_wrap();
        test_midstream_reset();
`ifdef IF_PREDECODE_EN
        test_predecode();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
